// File: rtl/cal_pulse_gen.sv
// cal_pulse_gen: programmable periodic/burst pulse source for the calibration path
module cal_pulse_gen #(
  parameter int CNT_WIDTH   = 32,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [CNT_WIDTH-1:0]   period_i,
  input  logic [CNT_WIDTH-1:0]   width_i,
  input  logic [BURST_WIDTH-1:0] burst_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic                   run_i,
  output logic                   sig_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [BURST_WIDTH-1:0] pulse_cnt_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] period_q, period_d, width_q, width_d, c_q, c_d, c_inc;
  logic [BURST_WIDTH-1:0] burst_q, burst_d, cnt_d;
  logic loaded_q, loaded_d, pend_q, pend_d, run_q, sig_d, done_d, err_d;
  logic hs, cfg_ok, rise, wrap;
  assign cfg_ready_o = state_q == IDLE;
  assign busy_o      = state_q == RUN;
  assign hs          = cfg_valid_i & cfg_ready_o;
  assign cfg_ok      = period_i >= CNT_WIDTH'(2) && width_i != '0 && width_i < period_i;
  assign rise        = run_i & ~run_q;
  assign wrap        = c_q == period_q - CNT_WIDTH'(1);
  assign c_inc       = wrap ? '0 : c_q + CNT_WIDTH'(1);
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    width_d  = width_q;
    burst_d  = burst_q;
    loaded_d = loaded_q;
    pend_d   = pend_q | rise;
    c_d      = c_q;
    sig_d    = sig_o;
    done_d   = 1'b0;
    err_d    = err_o;
    cnt_d    = pulse_cnt_o;
    if (state_q == IDLE) begin
      if (hs) begin
        if (cfg_ok) begin
          period_d = period_i;
          width_d  = width_i;
          burst_d  = burst_i;
          loaded_d = 1'b1;
          err_d    = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end else if (pend_q) begin
        // a fresh edge in this very cycle must survive the consumption of the old one
        pend_d = rise;
        if (loaded_q) begin
          state_d = RUN;
          sig_d   = 1'b1;
          c_d     = '0;
          cnt_d   = BURST_WIDTH'(1);
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      c_d   = c_inc;
      sig_d = c_inc < width_q;
      cnt_d = wrap ? pulse_cnt_o + BURST_WIDTH'(1) : pulse_cnt_o;
      if (wrap && !run_i) begin
        state_d = IDLE;
        sig_d   = 1'b0;
        cnt_d   = pulse_cnt_o;
      end else if (wrap && burst_q != '0 && pulse_cnt_o == burst_q) begin
        state_d = IDLE;
        sig_d   = 1'b0;
        done_d  = 1'b1;
        cnt_d   = pulse_cnt_o;
      end
    end
  end
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      period_q    <= '0;
      width_q     <= '0;
      burst_q     <= '0;
      loaded_q    <= 1'b0;
      pend_q      <= 1'b0;
      run_q       <= 1'b0;
      c_q         <= '0;
      sig_o       <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      pulse_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      width_q     <= width_d;
      burst_q     <= burst_d;
      loaded_q    <= loaded_d;
      pend_q      <= pend_d;
      run_q       <= run_i;
      c_q         <= c_d;
      sig_o       <= sig_d;
      done_o      <= done_d;
      err_o       <= err_d;
      pulse_cnt_o <= cnt_d;
    end
  end
endmodule

// File: tb/tb_cal_pulse_gen.sv
// tb_cal_pulse_gen: directed, table-driven and randomized checks of cal_pulse_gen
module tb_cal_pulse_gen;
  logic        clk_i = 1'b0, arst_i = 1'b1;
  logic [31:0] period_i = '0, width_i = '0;
  logic [15:0] burst_i = '0;
  logic        cfg_valid_i = 1'b0, run_i = 1'b0;
  logic        cfg_ready_o, sig_o, busy_o, done_o, err_o;
  logic [15:0] pulse_cnt_o;
  int errors = 0, checks = 0;
  typedef struct {
    logic [31:0] p;
    logic [31:0] w;
    logic [15:0] b;
    logic        exp_err;
  } cfg_vec_t;
  cfg_vec_t vec[9];
  always #5 clk_i = ~clk_i;
  cal_pulse_gen dut (
    .clk_i(clk_i), .arst_i(arst_i), .period_i(period_i), .width_i(width_i),
    .burst_i(burst_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .run_i(run_i), .sig_o(sig_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .pulse_cnt_o(pulse_cnt_o)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask
  task automatic do_reset;
    arst_i = 1'b1;
    cfg_valid_i = 1'b0;
    run_i = 1'b0;
    #2;
    arst_i = 1'b0;
    tick();
  endtask
  task automatic load(input logic [31:0] p, input logic [31:0] w, input logic [15:0] b);
    period_i = p;
    width_i = w;
    burst_i = b;
    cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
  endtask
  // reference model state: a run is described only by elapsed cycles since its first rise
  bit          m_run, m_loaded, m_pend, m_runq, m_err, m_done;
  longint      m_t, m_per, m_wid, m_bur;
  logic [15:0] m_cnt;
  function automatic logic [20:0] m_out();
    logic m_sig;
    m_sig = m_run && ((m_t % m_per) < m_wid);
    return {m_sig, m_run, m_done, m_err, ~m_run, m_cnt};
  endfunction
  task automatic m_step(input bit cv, input longint p, input longint w, input longint b, input bit r);
    bit rise, last;
    rise = r && !m_runq;
    m_done = 0;
    if (!m_run) begin
      if (cv) begin
        if (p >= 2 && w >= 1 && w < p) begin
          m_per = p; m_wid = w; m_bur = b; m_loaded = 1; m_err = 0;
        end else m_err = 1;
        m_pend = m_pend || rise;
      end else if (m_pend) begin
        if (m_loaded) begin
          m_run = 1; m_t = 0;
        end else m_err = 1;
        m_pend = rise;
      end else m_pend = rise;
    end else begin
      last = (m_t % m_per) == m_per - 1;
      if (last && !r) m_run = 0;
      else if (last && m_bur != 0 && m_t / m_per + 1 == m_bur) begin
        m_run = 0; m_done = 1;
      end else m_t++;
      m_pend = m_pend || rise;
    end
    if (m_run) m_cnt = 16'(m_t / m_per + 1);
    m_runq = r;
  endtask
  initial begin
    int bad, rises;
    bit prev;
    vec[0] = '{32'd4, 32'd4, 16'd0, 1'b1};
    vec[1] = '{32'd10, 32'd2, 16'd0, 1'b0};
    vec[2] = '{32'd1, 32'd0, 16'd0, 1'b1};
    vec[3] = '{32'd2, 32'd1, 16'd3, 1'b0};
    vec[4] = '{32'd5, 32'd0, 16'd0, 1'b1};
    vec[5] = '{32'd3, 32'd5, 16'd0, 1'b1};
    vec[6] = '{32'd0, 32'd0, 16'd0, 1'b1};
    vec[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 16'd0, 1'b0};
    vec[8] = '{32'd7, 32'd6, 16'd1, 1'b0};
    #2;
    chk("reset_outs", {sig_o, busy_o, done_o, err_o, cfg_ready_o, pulse_cnt_o}, {5'b00001, 16'd0});
    arst_i = 1'b0;
    tick();
    // basic continuous train
    load(125, 3, 0);
    chk("basic_cfg_err", err_o, 0);
    run_i = 1'b1;
    tick();
    chk("start_lat_pend", {sig_o, busy_o}, 2'b00);
    tick();
    for (int p = 0; p < 10; p++) begin
      bad = 0;
      for (int t = 0; t < 125; t++) begin
        if (sig_o !== (t < 3) || busy_o !== 1'b1) bad++;
        if (p == 9 && t == 1) begin
          chk("train_cnt10", pulse_cnt_o, 10);
          run_i = 1'b0;
        end
        tick();
      end
      chk($sformatf("train_period%0d", p), bad, 0);
    end
    chk("train_stop", {sig_o, busy_o, done_o, cfg_ready_o, pulse_cnt_o}, {4'b0001, 16'd10});
    // burst of 5
    load(4, 1, 5);
    run_i = 1'b1;
    tick(2);
    bad = 0; rises = 0; prev = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (sig_o !== ((t % 4) == 0) || done_o !== 1'b0 || busy_o !== 1'b1) bad++;
      if (sig_o && !prev) rises++;
      prev = sig_o;
      tick();
    end
    chk("burst_shape", bad, 0);
    chk("burst_rises", rises, 5);
    chk("burst_end", {sig_o, busy_o, done_o, pulse_cnt_o}, {3'b001, 16'd5});
    tick();
    chk("burst_done_1cyc", {done_o, busy_o, sig_o}, 3'b000);
    run_i = 1'b0;
    tick();
    // invalid config right after reset, then a start that must not run
    do_reset();
    load(4, 4, 0);
    chk("inv_err", {err_o, cfg_ready_o}, 2'b11);
    run_i = 1'b1;
    bad = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (sig_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    chk("inv_no_pulse", bad, 0);
    run_i = 1'b0;
    tick();
    load(10, 2, 0);
    chk("valid_clears_err", err_o, 0);
    // table of configs: err_o follows validity of the latest handshake
    for (int i = 0; i < 9; i++) begin
      load(vec[i].p, vec[i].w, vec[i].b);
      chk($sformatf("cfg_vec%0d", i), {err_o, cfg_ready_o}, {vec[i].exp_err, 1'b1});
    end
    // start with no config
    do_reset();
    run_i = 1'b1;
    tick();
    chk("nocfg_err_lat", err_o, 0);
    tick();
    chk("nocfg_err", {err_o, sig_o, busy_o}, 3'b100);
    tick(3);
    chk("nocfg_sig", {sig_o, busy_o}, 2'b00);
    run_i = 1'b0;
    tick();
    // handshake while a start is pending delays it and the new config is used
    do_reset();
    load(3, 1, 0);
    run_i = 1'b1;
    tick();
    period_i = 6; width_i = 2; burst_i = 0; cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    chk("pend_hs_delay", {sig_o, busy_o}, 2'b00);
    tick();
    chk("pend_hs_start", {sig_o, busy_o}, 2'b11);
    bad = 0;
    for (int t = 0; t < 12; t++) begin
      if (t == 3) begin
        period_i = 8; width_i = 3; cfg_valid_i = 1'b1;
        chk("run_cfg_ready", cfg_ready_o, 0);
      end
      if (sig_o !== ((t % 6) < 2)) bad++;
      tick();
    end
    cfg_valid_i = 1'b0;
    for (int t = 12; t < 18; t++) begin
      if (sig_o !== ((t % 6) < 2)) bad++;
      tick();
    end
    chk("period6_kept", bad, 0);
    // asynchronous reset while high
    chk("pre_arst_high", sig_o, 1);
    arst_i = 1'b1;
    #1;
    chk("arst_async", {sig_o, busy_o, done_o, err_o, cfg_ready_o, pulse_cnt_o}, {5'b00001, 16'd0});
    run_i = 1'b0;
    #1;
    arst_i = 1'b0;
    tick();
    // randomized stimulus against the elapsed-time model
    do_reset();
    m_run = 0; m_loaded = 0; m_pend = 0; m_runq = 0; m_err = 0; m_done = 0;
    m_t = 0; m_per = 1; m_wid = 0; m_bur = 0; m_cnt = '0;
    bad = 0;
    for (int i = 0; i < 4000; i++) begin
      cfg_valid_i = $urandom_range(0, 5) == 0;
      period_i = $urandom_range(0, 7);
      width_i = $urandom_range(0, 7);
      burst_i = $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) run_i = ~run_i;
      m_step(cfg_valid_i, longint'(period_i), longint'(width_i), longint'(burst_i), run_i);
      tick();
      chk("rand", {sig_o, busy_o, done_o, err_o, cfg_ready_o, pulse_cnt_o}, m_out());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
